npusch_ru_scheduler: RTL and testbench
======================================

// Module: npusch_ru_scheduler
// PURPOSE
//  Sequences one NPUSCH uplink grant for the subcarrier-mapping datapath: decodes ISC into tone start/count,
//  walks slots (7 SC-FDMA symbols each) over n_ru resource units, and emits one beat per (symbol, tone)
//  with the symbol-memory read address. DMRS symbols are flagged for reference insertion and consume no address.
//  Sits between the MAC grant interface and the symbol buffer / per-tone register file feeding the IFFT.
// PARAMETERS
//  ADDR_W    11  symbol-memory address width; the address wraps modulo 2^ADDR_W
//  NRU_W     3   width of the n_ru field; legal range is 1..2^NRU_W-1
//  DMRS_SYM  3   symbol index (0..6) inside each slot that carries DMRS
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high
//  start      in   1       grant strobe; sampled only in IDLE
//  isc        in   5       subcarrier indication; 0..18 legal
//  n_ru       in   NRU_W   number of resource units; 0 is illegal
//  base_addr  in   ADDR_W  address of the first data symbol
//  out_valid  out  1       beat valid
//  out_ready  in   1       downstream accepts the beat
//  rd_addr    out  ADDR_W  symbol-memory address (data beats only)
//  tone_idx   out  4       subcarrier 0..11 of this beat
//  dmrs       out  1       beat is a DMRS position; rd_addr is don't-care
//  sym_idx    out  3       symbol index in slot, 0..6
//  sym_last   out  1       last tone of the current symbol
//  slot_idx   out  8       slot counter within the grant, from 0
//  busy       out  1       a grant is in progress
//  done       out  1       1-cycle pulse after the final beat is accepted
//  cfg_err    out  1       1-cycle pulse when start carries an illegal isc or n_ru
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; all counters 0. Takes effect mid-grant; the grant is abandoned and no done pulse is issued.
//  ISC decode (registered on start):
//    0..11 -> tone_base=isc, tone_cnt=1, slots/RU=16
//    12..15 -> tone_base=3*(isc-12), tone_cnt=3, slots/RU=8
//    16..17 -> tone_base=6*(isc-16), tone_cnt=6, slots/RU=4
//    18 -> tone_base=0, tone_cnt=12, slots/RU=2
//    19..31, or n_ru=0 -> cfg_err=1 for one cycle; stay in IDLE; busy stays 0.
//  Total slots = slots/RU * n_ru, at most 16*7=112 (fits 8 bits).
//  FSM:
//    IDLE --start&legal--> RUN. Inputs are captured on that edge; busy=1 and out_valid=1 on the next cycle.
//    RUN: one beat per out_valid&out_ready.
//    RUN --last beat accepted--> DONE. DONE lasts one cycle with done=1, then returns to IDLE with busy=0.
//  Beat order: tone_idx runs tone_base..tone_base+tone_cnt-1 (innermost), then sym_idx 0..6, then slot_idx.
//  dmrs=1 iff sym_idx==DMRS_SYM. sym_last=1 on the final tone of each symbol.
//  rd_addr starts at base_addr, increments by 1 after each accepted non-DMRS beat, and wraps 2^ADDR_W-1 -> 0.
//  Handshake: while out_valid & !out_ready, all beat outputs hold stable. out_valid never drops mid-grant.
//  start while busy or in DONE: ignored, no cfg_err. Simultaneous reset & start: reset wins.
//  Grant beat counts: 7*tone_cnt*total_slots; data beats = 6*tone_cnt*total_slots.
// TESTING
//  T1 isc=18, n_ru=1, base=0, ready=1:
//     -> 168 beats; tone_idx 0..11 repeating; beats 36..47 dmrs=1; data addr 0..143;
//     -> done one cycle after beat 167; busy falls the following cycle.
//  T2 isc=5, n_ru=2, base=100:
//     -> tone_idx always 5; 224 beats over slots 0..31; last data rd_addr=291; sym_last=1 on every beat.
//  T3 isc=13, n_ru=1, random out_ready (~50%):
//     -> tone_idx cycles 3,4,5; outputs stable while stalled; 168 beats; addr 0..143 with no skips or repeats.
//  T4 start with isc=20, then with isc=18 and n_ru=0:
//     -> cfg_err pulses 1 cycle each time; busy=0; out_valid=0.
//  T5 ADDR_W=11, base=2040, isc=16, n_ru=1:
//     -> rd_addr 2040..2047, then 0,1,...; 144 data beats ending at 135.
//  T6 reset at beat 50 of T1, then a new start (isc=0, n_ru=1):
//     -> all outputs 0 the cycle after reset; no done pulse; new grant gives 112 beats with tone_idx=0.

Source files
------------

// File: rtl/npusch_ru_scheduler_if.sv
// Grant-in / beat-out bundle for the NPUSCH RU scheduler.
// The master modport is the scheduler side; the slave modport is the grant source plus beat consumer.
interface npusch_ru_scheduler_if #(
  parameter int ADDR_W = 11,
  parameter int NRU_W  = 3
);
  logic              start;
  logic [4:0]        isc;
  logic [NRU_W-1:0]  n_ru;
  logic [ADDR_W-1:0] base_addr;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        tone_idx;
  logic              dmrs;
  logic [2:0]        sym_idx;
  logic              sym_last;
  logic [7:0]        slot_idx;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport master (
    input  start, isc, n_ru, base_addr, out_ready,
    output out_valid, rd_addr, tone_idx, dmrs, sym_idx, sym_last, slot_idx, busy, done, cfg_err
  );

  modport slave (
    output start, isc, n_ru, base_addr, out_ready,
    input  out_valid, rd_addr, tone_idx, dmrs, sym_idx, sym_last, slot_idx, busy, done, cfg_err
  );
endinterface

// File: rtl/npusch_ru_scheduler.sv
// Sequences one NPUSCH grant into (slot, symbol, tone) beats with symbol-memory read addresses.
// First beat one cycle after start; beats advance only on out_valid & out_ready and hold while stalled.
module npusch_ru_scheduler #(
  parameter int ADDR_W   = 11,
  parameter int NRU_W    = 3,
  parameter int DMRS_SYM = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  npusch_ru_scheduler_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [3:0]        dec_base;
  logic [3:0]        dec_cnt;
  logic [2:0]        dec_shift;
  logic [7:0]        dec_slots;
  logic              legal;

  logic [3:0]        tone_base, tone_last, tone;
  logic [2:0]        sym;
  logic [7:0]        slot, slot_last;
  logic [ADDR_W-1:0] addr;
  logic              cfg_err_q;

  logic run, accept, is_dmrs, last_tone, last_sym, last_slot, last_beat, grant_ok;

  // ISC -> tone allocation; slots per RU is 2^dec_shift
  always_comb begin
    dec_base  = 4'd0;
    dec_cnt   = 4'd1;
    dec_shift = 3'd4;
    case (bus.isc) inside
      [5'd0:5'd11]: begin dec_base = bus.isc[3:0]; dec_cnt = 4'd1; dec_shift = 3'd4; end
      5'd12:        begin dec_base = 4'd0;  dec_cnt = 4'd3;  dec_shift = 3'd3; end
      5'd13:        begin dec_base = 4'd3;  dec_cnt = 4'd3;  dec_shift = 3'd3; end
      5'd14:        begin dec_base = 4'd6;  dec_cnt = 4'd3;  dec_shift = 3'd3; end
      5'd15:        begin dec_base = 4'd9;  dec_cnt = 4'd3;  dec_shift = 3'd3; end
      5'd16:        begin dec_base = 4'd0;  dec_cnt = 4'd6;  dec_shift = 3'd2; end
      5'd17:        begin dec_base = 4'd6;  dec_cnt = 4'd6;  dec_shift = 3'd2; end
      5'd18:        begin dec_base = 4'd0;  dec_cnt = 4'd12; dec_shift = 3'd1; end
      default:      begin dec_base = 4'd0;  dec_cnt = 4'd1;  dec_shift = 3'd4; end
    endcase
  end

  assign dec_slots = 8'(bus.n_ru) << dec_shift;
  assign legal     = (bus.isc <= 5'd18) && (bus.n_ru != '0);
  assign grant_ok  = (state == IDLE) && bus.start && legal;

  assign run       = (state == RUN);
  assign accept    = run && bus.out_ready;
  assign is_dmrs   = (sym == 3'(DMRS_SYM));
  assign last_tone = (tone == tone_last);
  assign last_sym  = (sym == 3'd6);
  assign last_slot = (slot == slot_last);
  assign last_beat = last_tone && last_sym && last_slot;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_ok) state_nx = RUN;
      RUN:     if (accept && last_beat) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tone_base <= '0;
      tone_last <= '0;
      tone      <= '0;
      sym       <= '0;
      slot      <= '0;
      slot_last <= '0;
      addr      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state == IDLE) && bus.start && !legal;
      if (grant_ok) begin
        tone_base <= dec_base;
        tone_last <= dec_base + dec_cnt - 4'd1;
        tone      <= dec_base;
        sym       <= '0;
        slot      <= '0;
        slot_last <= dec_slots - 8'd1;
        addr      <= bus.base_addr;
      end else if (accept) begin
        // DMRS beats carry no data, so the memory pointer skips them
        if (!is_dmrs) addr <= addr + ADDR_W'(1);
        if (last_tone) begin
          tone <= tone_base;
          if (last_sym) begin
            sym  <= '0;
            slot <= slot + 8'd1;
          end else begin
            sym <= sym + 3'd1;
          end
        end else begin
          tone <= tone + 4'd1;
        end
      end
    end
  end

  assign bus.out_valid = run;
  assign bus.rd_addr   = run ? addr : '0;
  assign bus.tone_idx  = run ? tone : '0;
  assign bus.dmrs      = run && is_dmrs;
  assign bus.sym_idx   = run ? sym : '0;
  assign bus.sym_last  = run && last_tone;
  assign bus.slot_idx  = run ? slot : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_npusch_ru_scheduler.sv
// Directed bench for npusch_ru_scheduler: a reference model fills a beat queue per grant,
// and every valid cycle is compared against the queue head.
module tb_npusch_ru_scheduler;

  typedef struct packed {
    logic [3:0]  tone;
    logic        dmrs;
    logic [2:0]  sym;
    logic        sym_last;
    logic [7:0]  slot;
    logic [10:0] addr;
  } beat_t;

  logic  clk;
  logic  reset;
  beat_t q[$];
  int    tests;
  int    fails;

  npusch_ru_scheduler_if #(.ADDR_W(11), .NRU_W(3)) bus ();

  npusch_ru_scheduler #(.ADDR_W(11), .NRU_W(3), .DMRS_SYM(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {bus.out_valid, bus.rd_addr, bus.tone_idx, bus.dmrs, bus.sym_idx,
            bus.sym_last, bus.slot_idx, bus.busy, bus.done, bus.cfg_err};
  endfunction

  function automatic beat_t obs_beat();
    beat_t b;
    b.tone     = bus.tone_idx;
    b.dmrs     = bus.dmrs;
    b.sym      = bus.sym_idx;
    b.sym_last = bus.sym_last;
    b.slot     = bus.slot_idx;
    b.addr     = bus.dmrs ? 11'd0 : bus.rd_addr;
    return b;
  endfunction

  task automatic push_grant(input int isc, input int nru, input int base);
    int tb, tc, spr, a;
    beat_t b;
    if (isc < 12)      begin tb = isc;            tc = 1;  spr = 16; end
    else if (isc < 16) begin tb = 3 * (isc - 12); tc = 3;  spr = 8;  end
    else if (isc < 18) begin tb = 6 * (isc - 16); tc = 6;  spr = 4;  end
    else               begin tb = 0;              tc = 12; spr = 2;  end
    a = base;
    for (int s = 0; s < spr * nru; s++)
      for (int y = 0; y < 7; y++)
        for (int t = 0; t < tc; t++) begin
          b.tone     = 4'(tb + t);
          b.dmrs     = (y == 3);
          b.sym      = 3'(y);
          b.sym_last = (t == tc - 1);
          b.slot     = 8'(s);
          b.addr     = b.dmrs ? 11'd0 : 11'(a);
          if (!b.dmrs) a = (a + 1) % 2048;
          q.push_back(b);
        end
  endtask

  task automatic run_grant(input int isc, input int nru, input int base, input bit rnd,
                           input int abort_at, input bit poke, input int exp_beats, input int exp_last);
    int          cnt;
    int          guard;
    logic [10:0] last_addr;
    bit          poked, poke_pending, aborted;
    cnt = 0; guard = 0; last_addr = '0; poked = 0; poke_pending = 0; aborted = 0;

    @(negedge clk);
    bus.start     = 1'b1;
    bus.isc       = 5'(isc);
    bus.n_ru      = 3'(nru);
    bus.base_addr = 11'(base);
    push_grant(isc, nru, base);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);

    while (q.size() > 0 && guard < 20000) begin
      guard++;
      if (poke_pending) begin
        bus.start = 1'b0;
        check("cfg_err_start_while_busy", 32'(bus.cfg_err), 32'd0);
        poke_pending = 0;
      end
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check("valid_mid_grant", 32'(bus.out_valid), 32'd1);
      check("beat", 32'(obs_beat()), 32'(q[0]));
      if (bus.out_valid && bus.out_ready) begin
        if (!bus.dmrs) last_addr = bus.rd_addr;
        void'(q.pop_front());
        cnt++;
      end
      if (poke && cnt == 10 && !poked) begin
        bus.start = 1'b1;
        bus.isc   = 5'd31;
        poked = 1;
        poke_pending = 1;
      end
      if (abort_at != 0 && cnt == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        aborted = 1;
        break;
      end
      @(negedge clk);
    end

    if (aborted) begin
      check("outputs_zero_after_reset", outs(), 32'd0);
      reset = 1'b0;
      q.delete();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("no_done_after_abort", {31'd0, bus.done}, 32'd0);
      end
      return;
    end

    check("grant_finished_in_budget", 32'(q.size()), 32'd0);
    check("beat_count", 32'(cnt), 32'(exp_beats));
    check("last_data_addr", 32'(last_addr), 32'(exp_last));
    check("done_pulse", {29'd0, bus.done, bus.busy, bus.out_valid}, 32'b110);
    if (poke) begin
      bus.start = 1'b1;
      bus.isc   = 5'd18;
      bus.n_ru  = 3'd1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_after_done", {29'd0, bus.done, bus.busy, bus.out_valid}, 32'b000);
    if (poke) begin
      @(negedge clk);
      check("start_in_done_ignored", {30'd0, bus.busy, bus.out_valid}, 32'b00);
    end
  endtask

  task automatic bad_start(input int isc, input int nru, input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    bus.isc   = 5'(isc);
    bus.n_ru  = 3'(nru);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_cfg_err"}, {29'd0, bus.cfg_err, bus.busy, bus.out_valid}, 32'b100);
    @(negedge clk);
    check({tag, "_cfg_err_one_cycle"}, {29'd0, bus.cfg_err, bus.busy, bus.out_valid}, 32'b000);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.isc = '0;
    bus.n_ru = '0;
    bus.base_addr = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs(), 32'd0);

    // T1: full 12-tone grant, also pokes start mid-grant and during DONE
    run_grant(18, 1, 0, 1'b0, 0, 1'b1, 168, 143);
    // T2: single tone, two RUs
    run_grant(5, 2, 100, 1'b0, 0, 1'b0, 224, 291);
    // T3: three tones with random backpressure
    run_grant(13, 1, 0, 1'b1, 0, 1'b0, 168, 143);
    // T4: illegal configurations
    bad_start(20, 1, "isc20");
    bad_start(18, 0, "nru0");
    // T5: address wrap
    run_grant(16, 1, 2040, 1'b0, 0, 1'b0, 168, 135);
    // T6: reset mid-grant, then a fresh single-tone grant
    run_grant(18, 1, 0, 1'b0, 50, 1'b0, 168, 143);
    run_grant(0, 1, 0, 1'b0, 0, 1'b0, 112, 95);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
